// File: rtl/cache_access_adapter_if.sv
// rtl/cache_access_adapter_if.sv - CPU load/store and word-cache port bundle for the cache access adapter
interface cache_access_adapter_if #(
    parameter int AddressBitWidth = 32
);
    logic                       cpu_req;
    logic                       cpu_ready;
    logic [AddressBitWidth-1:0] cpu_addr;
    logic [31:0]                cpu_wdata;
    logic                       cpu_write;
    logic [1:0]                 cpu_size;
    logic                       cpu_signed;
    logic [31:0]                cpu_rdata;
    logic                       cpu_done;
    logic                       cpu_error;
    logic                       cache_enable;
    logic [AddressBitWidth-1:0] cache_address;
    logic [31:0]                cache_data_in;
    logic [3:0]                 cache_write_enable;
    logic                       cache_busy;
    logic [31:0]                cache_data_out;
    logic                       cache_data_out_ready;

    // master: the adapter (serves the CPU, drives the cache); slave: the CPU and cache around it
    modport master (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_write, cpu_size, cpu_signed,
        output cpu_ready, cpu_rdata, cpu_done, cpu_error,
        output cache_enable, cache_address, cache_data_in, cache_write_enable,
        input  cache_busy, cache_data_out, cache_data_out_ready
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_wdata, cpu_write, cpu_size, cpu_signed,
        input  cpu_ready, cpu_rdata, cpu_done, cpu_error,
        input  cache_enable, cache_address, cache_data_in, cache_write_enable,
        output cache_busy, cache_data_out, cache_data_out_ready
    );
endinterface

// File: rtl/cache_access_adapter.sv
// rtl/cache_access_adapter.sv - byte/half/word load-store to word-cache adapter; CACHE_ACCESS_SPLIT_EN splits misaligned accesses
module cache_access_adapter #(
    parameter int AddressBitWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_access_adapter_if.master bus
);

`ifdef CACHE_ACCESS_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCESS,
        HOLD,
        DONE
    } state_t;

    state_t                     state;
    logic [AddressBitWidth-3:0] word_addr;
    logic [1:0]                 off;
    logic                       wr;
    logic [1:0]                 size_r;
    logic                       sgn;
    logic                       split;
    logic                       part2;
    logic [3:0]                 cur_mask;
    logic [3:0]                 mask_hi;
    logic [31:0]                data_hi;
    logic [31:0]                rd_lo;
    logic [31:0]                rd_hi;

    logic [1:0]                 req_off;
    logic [3:0]                 req_mask_base;
    logic [7:0]                 req_mask;
    logic [63:0]                req_data;
    logic                       req_misaligned;
    logic [AddressBitWidth-3:0] next_word;
    logic [31:0]                rd_shift;
    logic [31:0]                load_fmt;

    always_comb begin
        req_off = bus.cpu_addr[1:0];
        case (bus.cpu_size)
            2'd0:    req_mask_base = 4'b0001;
            2'd1:    req_mask_base = 4'b0011;
            default: req_mask_base = 4'b1111;
        endcase
        // Mask and data are shifted across two words so a split access can take its upper half as-is
        req_mask       = {4'b0000, req_mask_base} << req_off;
        req_data       = {32'h0, bus.cpu_wdata} << {req_off, 3'b000};
        req_misaligned = ((bus.cpu_size == 2'd1) && (req_off == 2'd3)) ||
                         (bus.cpu_size[1] && (req_off != 2'd0));
    end

    always_comb begin
        next_word = word_addr + 1'b1;
        rd_shift  = 32'({rd_hi, rd_lo} >> {off, 3'b000});
        case (size_r)
            2'd0:    load_fmt = {{24{sgn & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    load_fmt = {{16{sgn & rd_shift[15]}}, rd_shift[15:0]};
            default: load_fmt = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= IDLE;
            word_addr              <= '0;
            off                    <= '0;
            wr                     <= 1'b0;
            size_r                 <= '0;
            sgn                    <= 1'b0;
            split                  <= 1'b0;
            part2                  <= 1'b0;
            cur_mask               <= '0;
            mask_hi                <= '0;
            data_hi                <= '0;
            rd_lo                  <= '0;
            rd_hi                  <= '0;
            bus.cpu_ready          <= 1'b1;
            bus.cpu_rdata          <= '0;
            bus.cpu_done           <= 1'b0;
            bus.cpu_error          <= 1'b0;
            bus.cache_enable       <= 1'b0;
            bus.cache_address      <= '0;
            bus.cache_data_in      <= '0;
            bus.cache_write_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        word_addr     <= bus.cpu_addr[AddressBitWidth-1:2];
                        off           <= req_off;
                        wr            <= bus.cpu_write;
                        size_r        <= bus.cpu_size;
                        sgn           <= bus.cpu_signed;
                        bus.cpu_ready <= 1'b0;
                        if (req_misaligned && !SplitEn) begin
                            bus.cpu_done  <= 1'b1;
                            bus.cpu_error <= 1'b1;
                            bus.cpu_rdata <= '0;
                            state         <= DONE;
                        end else begin
                            split             <= req_misaligned;
                            part2             <= 1'b0;
                            cur_mask          <= req_mask[3:0];
                            mask_hi           <= req_mask[7:4];
                            data_hi           <= req_data[63:32];
                            rd_lo             <= '0;
                            rd_hi             <= '0;
                            bus.cache_address <= {bus.cpu_addr[AddressBitWidth-1:2], 2'b00};
                            bus.cache_data_in <= req_data[31:0];
                            state             <= SETTLE;
                        end
                    end
                end
                // Address and data have been stable for a cycle; the tag RAM now shows the right line
                SETTLE: begin
                    bus.cache_enable       <= 1'b1;
                    bus.cache_write_enable <= wr ? cur_mask : 4'b0000;
                    state                  <= ACCESS;
                end
                ACCESS: begin
                    if (!bus.cache_busy && (wr || bus.cache_data_out_ready)) begin
                        if (!wr) begin
                            if (part2) rd_hi <= bus.cache_data_out;
                            else       rd_lo <= bus.cache_data_out;
                        end
                        bus.cache_enable       <= 1'b0;
                        bus.cache_write_enable <= 4'b0000;
                        state                  <= HOLD;
                    end
                end
                HOLD: begin
                    if (split && !part2) begin
                        part2             <= 1'b1;
                        word_addr         <= next_word;
                        cur_mask          <= mask_hi;
                        bus.cache_address <= {next_word, 2'b00};
                        bus.cache_data_in <= data_hi;
                        state             <= SETTLE;
                    end else begin
                        bus.cpu_done  <= 1'b1;
                        bus.cpu_error <= 1'b0;
                        bus.cpu_rdata <= wr ? 32'h0 : load_fmt;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.cpu_done  <= 1'b0;
                    bus.cpu_error <= 1'b0;
                    bus.cpu_rdata <= '0;
                    bus.cpu_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_adapter.sv
// tb/tb_cache_access_adapter.sv - self-checking bench for cache_access_adapter against a byte-memory reference model
module tb_cache_access_adapter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   miss_cycles;
    int   en_cnt;

    logic [7:0] cmem   [logic [31:0]];
    logic [7:0] refmem [logic [31:0]];

    cache_access_adapter_if #(.AddressBitWidth(32)) bus ();

    cache_access_adapter #(.AddressBitWidth(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] cm_rd(input logic [31:0] a);
        return cmem.exists(a) ? cmem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] cm_word(input logic [31:0] a);
        return {cm_rd(a + 32'd3), cm_rd(a + 32'd2), cm_rd(a + 32'd1), cm_rd(a)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            cmem[a + 32'(i)]   = w[8*i +: 8];
            refmem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cache model: writes land at the edge that ends a non-busy enabled cycle
    always @(posedge clk) begin
        if (bus.cache_enable && !bus.cache_busy) begin
            for (int i = 0; i < 4; i++)
                if (bus.cache_write_enable[i])
                    cmem[bus.cache_address + 32'(i)] = bus.cache_data_in[8*i +: 8];
        end
        #1;
        if (bus.cache_enable) en_cnt++;
        else                  en_cnt = 0;
        bus.cache_busy           = bus.cache_enable && (en_cnt <= miss_cycles);
        bus.cache_data_out_ready = bus.cache_enable && !bus.cache_busy;
        bus.cache_data_out       = bus.cache_data_out_ready ? cm_word(bus.cache_address) : 32'h0;
    end

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int          n;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic do_op(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                         input logic [1:0] sz, input logic sg, input int miss, input bit pulse_extra);
        int          n, k, first_en, viol, exp_k, exp_first, extra_done, bad_bytes;
        bit          done, prev_en, mis, rejected;
        logic [31:0] held_di, rdata, err;
        logic [3:0]  held_we;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = (n == 2 && addr[1:0] == 2'd3) || (n == 4 && addr[1:0] != 2'd0);
`ifdef CACHE_ACCESS_SPLIT_EN
        rejected = 1'b0;
        exp_k    = mis ? 7 + 2 * miss : 4 + miss;
`else
        rejected = mis;
        exp_k    = mis ? 1 : 4 + miss;
`endif
        exp_first   = rejected ? 0 : 2;
        miss_cycles = miss;
        @(negedge clk);
        chk("ready_before_req", 32'(bus.cpu_ready), 32'd1);
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = addr;
        bus.cpu_wdata  = wdata;
        bus.cpu_write  = wr;
        bus.cpu_size   = sz;
        bus.cpu_signed = sg;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        k = 0; done = 0; first_en = 0; viol = 0; prev_en = 0;
        held_di = 32'h0; held_we = 4'h0; rdata = 32'h0; err = 32'h0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            if (pulse_extra) begin
                bus.cpu_req  = (k == 2);
                bus.cpu_addr = 32'h40;
            end
            if (bus.cache_address[1:0] != 2'b00) viol++;
            if (bus.cache_enable) begin
                if (first_en == 0) first_en = k;
                if (prev_en && (bus.cache_data_in !== held_di || bus.cache_write_enable !== held_we)) viol++;
                held_di = bus.cache_data_in;
                held_we = bus.cache_write_enable;
            end else if (bus.cache_write_enable != 4'b0000) begin
                viol++;
            end
            prev_en = bus.cache_enable;
            if (bus.cpu_done) begin
                done  = 1;
                rdata = bus.cpu_rdata;
                err   = 32'(bus.cpu_error);
            end
        end
        bus.cpu_req = 1'b0;
        chk($sformatf("done_seen a=%h", addr), 32'(done), 32'd1);
        chk($sformatf("done_cycle a=%h sz=%0d miss=%0d", addr, sz, miss), k, exp_k);
        chk($sformatf("first_enable a=%h", addr), first_en, exp_first);
        chk($sformatf("error a=%h", addr), err, 32'(rejected));
        chk($sformatf("bus_stable a=%h", addr), viol, 32'd0);
        if (rejected)
            chk($sformatf("rdata_reject a=%h", addr), rdata, 32'h0);
        else if (!wr)
            chk($sformatf("rdata a=%h sz=%0d sg=%0d", addr, sz, sg), rdata, exp_load(addr, sz, sg));
        if (wr && !rejected)
            for (int i = 0; i < n; i++) refmem[addr + 32'(i)] = wdata[8*i +: 8];
        bad_bytes = 0;
        for (int i = -4; i < 9; i++)
            if (cm_rd(addr + 32'(i)) !== ref_rd(addr + 32'(i))) bad_bytes++;
        chk($sformatf("memory a=%h", addr), bad_bytes, 32'd0);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cpu_done) extra_done++;
        end
        chk($sformatf("no_extra_done a=%h", addr), extra_done, 32'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] ra;
        errors = 0; checks = 0; miss_cycles = 0; en_cnt = 0;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_write = 1'b0; bus.cpu_size = '0; bus.cpu_signed = 1'b0;
        bus.cache_busy = 1'b0; bus.cache_data_out = '0; bus.cache_data_out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(bus.cpu_ready), 32'd1);
        chk("reset_done", 32'(bus.cpu_done), 32'd0);
        chk("reset_enable", 32'(bus.cache_enable), 32'd0);
        chk("reset_we", 32'(bus.cache_write_enable), 32'd0);
        chk("reset_addr", bus.cache_address, 32'h0);
        chk("reset_rdata", bus.cpu_rdata, 32'h0);
        rst_n = 1'b1;

        set_word(32'h100, 32'hDEADBEEF);
        do_op(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0);
        set_word(32'h100, 32'h80FF1234);
        do_op(32'h103, 32'h0, 1'b0, 2'd0, 1'b1, 0, 1'b0);
        do_op(32'h103, 32'h0, 1'b0, 2'd0, 1'b0, 1, 1'b0);
        do_op(32'h102, 32'h0000ABCD, 1'b1, 2'd1, 1'b0, 10, 1'b0);
        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        do_op(32'h101, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0);
        do_op(32'h20, 32'h0, 1'b0, 2'd1, 1'b1, 0, 1'b1);
        do_op(32'hFFFFFFFE, 32'h12345678, 1'b1, 2'd3, 1'b0, 1, 1'b0);

        // Reset while the cache is stalling the access
        miss_cycles = 6;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h200; bus.cpu_write = 1'b0; bus.cpu_size = 2'd2;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_access_enable", 32'(bus.cache_enable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_enable", 32'(bus.cache_enable), 32'd0);
        chk("rst_we", 32'(bus.cache_write_enable), 32'd0);
        chk("rst_addr", bus.cache_address, 32'h0);
        chk("rst_data_in", bus.cache_data_in, 32'h0);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.cpu_done) dones++;
            @(negedge clk);
        end
        chk("rst_no_done", dones, 32'd0);
        do_op(32'h200, 32'h0, 1'b0, 2'd2, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'($urandom_range(0, 255));
            do_op(ra, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
